spi_flash_reader: RTL

- Hardware sequencer for the on-board SPI flash pins (SCK, MISO, MOSI, CS), replacing CPU bit-banging through the misc.out/misc.in bits.
- The J1 programs a 24-bit start address and a byte count over the registered IO bus. The block then issues a READ command and streams bytes into a small FIFO, which the CPU pops through an IO read.
- Sits beside the UART on the `_`-delayed IO strobes. The top level does the address-bit decode.

---
 rtl/spi_flash_reader.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI flash READ sequencer with a small receive FIFO.
// The CPU programs a 24-bit start address and a byte count; the block issues
// a mode-0 read command and streams bytes into the FIFO, stalling SCK while full.
// Optional build macro FAST_READ_EN: use command 0x0B with 8 dummy clocks and
// report status bit 15 = 1.
module spi_flash_reader #(
  parameter int CLKDIV     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        sel,
  input  logic [1:0]  reg_a,
  input  logic        wr,
  input  logic        rd,
  input  logic [15:0] wd,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] DIV_LAST  = 8'(CLKDIV - 1);
  localparam logic [7:0] HOLD_CS   = 8'(CLKDIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(3 * CLKDIV - 1);
  localparam logic [4:0] DEPTH     = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA_WAIT, DATA, CS_HOLD
  } state_t;

`ifdef FAST_READ_EN
  localparam logic [7:0] READ_CMD   = 8'h0B;
  localparam logic       FAST_BIT   = 1'b1;
  localparam state_t     AFTER_ADDR = DUMMY;
`else
  localparam logic [7:0] READ_CMD   = 8'h03;
  localparam logic       FAST_BIT   = 1'b0;
  localparam state_t     AFTER_ADDR = DATA_WAIT;
`endif

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic [31:0]     tx_q, tx_d;
  logic [6:0]      rx_q, rx_d;
  logic [23:0]     addr_q, addr_d;
  logic [15:0]     rem_q, rem_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic            wr_addr_lo, wr_addr_hi, wr_len, wr_abort, pop, push, tick;
  logic [7:0]      rx_byte;

  assign wr_addr_lo = sel & wr & (reg_a == 2'd0);
  assign wr_addr_hi = sel & wr & (reg_a == 2'd1);
  assign wr_len     = sel & wr & (reg_a == 2'd2);
  assign wr_abort   = sel & wr & (reg_a == 2'd3);
  assign pop        = sel & rd & (reg_a == 2'd2) & (count_q != 5'd0);
  assign tick       = (cnt_q == DIV_LAST);
  assign rx_byte    = {rx_q, spi_miso};

  assign busy     = (state_q != IDLE);
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

  // Sequencer next state, SCK/MOSI generation, byte capture and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    push     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (wr_len) begin
          rem_d = wd;
          if (wd != 16'd0) begin
            state_d = CS_SETUP;
            cs_n_d  = 1'b0;
            cnt_d   = 8'd0;
            tx_d    = {READ_CMD, addr_q};
          end
        end
      end
      CS_SETUP: begin
        if (tick) begin
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
          mosi_d  = tx_q[31];
          state_d = CMD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (!tick) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (!sck_q) begin
            // Rising edge: this is also the MISO sampling edge.
            sck_d = 1'b1;
            if (state_q == DATA) begin
              rx_d = rx_byte[6:0];
              if (bit_q == 5'd7) begin
                push   = 1'b1;
                rem_d  = rem_q - 16'd1;
                addr_d = addr_q + 24'd1;
              end
            end
          end else begin
            // Falling edge: MOSI may only change while SCK is low.
            sck_d = 1'b0;
            bit_d = bit_q + 5'd1;
            if (state_q == CMD || state_q == ADDR) begin
              tx_d   = {tx_q[30:0], 1'b0};
              mosi_d = tx_q[30];
            end
            case (state_q)
              CMD:   if (bit_q == 5'd7)  begin bit_d = 5'd0; state_d = ADDR; end
              ADDR:  if (bit_q == 5'd23) begin bit_d = 5'd0; state_d = AFTER_ADDR; end
              DUMMY: if (bit_q == 5'd7)  begin bit_d = 5'd0; state_d = DATA_WAIT; end
              default: begin
                if (bit_q == 5'd7) begin
                  bit_d   = 5'd0;
                  state_d = (rem_q == 16'd0) ? CS_HOLD : DATA_WAIT;
                end
              end
            endcase
          end
        end
      end
      DATA_WAIT: begin
        // Only start a byte when it is guaranteed a free FIFO slot.
        if (count_q < DEPTH) begin
          state_d = DATA;
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
        end
      end
      CS_HOLD: begin
        if (cnt_q == HOLD_CS) cs_n_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_abort) begin
      state_d = IDLE;
      sck_d   = 1'b0;
      cs_n_d  = 1'b1;
      mosi_d  = 1'b0;
      rem_d   = 16'd0;
      cnt_d   = 8'd0;
      bit_d   = 5'd0;
      push    = 1'b0;
      addr_d  = addr_q;
    end

    if (wr_addr_lo) addr_d[15:0]  = wd;
    if (wr_addr_hi) addr_d[23:16] = wd[7:0];

    if (wr_abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + 5'd1;
      else if (!push && pop) count_d = count_q - 5'd1;
    end
  end

  // State registers, cleared asynchronously so pins go idle without a clock.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 5'd0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      tx_q     <= 32'd0;
      rx_q     <= 7'd0;
      addr_q   <= 24'd0;
      rem_q    <= 16'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_byte;
  end

  // Register read mux; an empty FIFO reads as zero.
  always_comb begin
    rdata = 16'd0;
    case (reg_a)
      2'd0:    rdata = {FAST_BIT, 7'd0, count_q, (count_q == DEPTH), (count_q == 5'd0), busy};
      2'd1:    rdata = addr_q[15:0];
      2'd2:    if (count_q != 5'd0) rdata = {8'd0, fifo_mem[rd_ptr_q]};
      default: rdata = rem_q;
    endcase
  end

endmodule
